// File: rtl/instr_collater_pkg.sv
// instr_collater_pkg: shared constants and pending-entry type for instruction collation
package instr_collater_pkg;
  localparam int NUM_WF = 40;
  localparam int WFID_W = 6;
  typedef struct packed {
    logic        valid;
    logic [31:0] word;
    logic [31:0] pc;
  } collate_entry_t;
endpackage

// File: rtl/collate_pending_table.sv
// collate_pending_table: per-wavefront parked low words; clear and flush beat a same-cycle set
module collate_pending_table
  import instr_collater_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [WFID_W-1:0] i_rd_wfid,
  output collate_entry_t    o_rd_entry,
  input  logic              i_set,
  input  logic [WFID_W-1:0] i_set_wfid,
  input  logic [31:0]       i_set_word,
  input  logic [31:0]       i_set_pc,
  input  logic              i_clr,
  input  logic [WFID_W-1:0] i_clr_wfid,
  input  logic              i_flush,
  input  logic [WFID_W-1:0] i_flush_wfid
);
  logic [NUM_WF-1:0] r_valid;
  logic [31:0]       r_word [NUM_WF];
  logic [31:0]       r_pc   [NUM_WF];
  assign o_rd_entry = {r_valid[i_rd_wfid], r_word[i_rd_wfid], r_pc[i_rd_wfid]};
  always_ff @(posedge clk)
    if (rst) r_valid <= '0;
    else
      for (int k = 0; k < NUM_WF; k++) begin
        if ((i_clr && i_clr_wfid == WFID_W'(k)) || (i_flush && i_flush_wfid == WFID_W'(k)))
          r_valid[k] <= 1'b0;
        else if (i_set && i_set_wfid == WFID_W'(k))
          r_valid[k] <= 1'b1;
        if (i_set && i_set_wfid == WFID_W'(k)) begin
          r_word[k] <= i_set_word;
          r_pc[k]   <= i_set_pc;
        end
      end
endmodule

// File: rtl/instr_collater.sv
// instr_collater: stages 32-bit words for decode_core and merges 64-bit halves per wavefront
module instr_collater
  import instr_collater_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ib_valid,
  input  logic [31:0]       ib_instr,
  input  logic [31:0]       ib_pc,
  input  logic [WFID_W-1:0] ib_wfid,
  output logic              ib_ready,
  input  logic              flush_valid,
  input  logic [WFID_W-1:0] flush_wfid,
  output logic [63:0]       col_instr,
  output logic              col_done,
  input  logic              collate_required,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic [WFID_W-1:0] dec_wfid,
  output logic [31:0]       dec_pc,
  output logic              collate_err
);
  logic           r_out_valid;
  logic           w_park, w_err, w_acc, w_bypass, w_hit, w_load, w_free;
  logic [31:0]    w_lo_word, w_lo_pc;
  collate_entry_t w_pend;
  assign dec_valid = r_out_valid && !collate_required;
  assign ib_ready  = !r_out_valid || collate_required || dec_ready;
  assign w_park    = r_out_valid && collate_required && !col_done;
  assign w_err     = r_out_valid && collate_required && col_done;
  assign w_acc     = ib_valid && ib_ready;
  // a low word leaving the stage can pair with its high word in the same cycle
  assign w_bypass  = w_park && w_acc && ib_wfid == dec_wfid;
  assign w_hit     = w_bypass || w_pend.valid;
  assign w_lo_word = w_bypass ? col_instr[31:0] : w_pend.word;
  assign w_lo_pc   = w_bypass ? dec_pc : w_pend.pc;
  assign w_load    = w_acc && !(flush_valid && ib_wfid == flush_wfid);
  assign w_free    = w_park || w_err || (dec_valid && dec_ready) || (flush_valid && dec_wfid == flush_wfid);
  collate_pending_table u_tab (
    .clk         (clk),
    .rst         (rst),
    .i_rd_wfid   (ib_wfid),
    .o_rd_entry  (w_pend),
    .i_set       (w_park && !w_bypass),
    .i_set_wfid  (dec_wfid),
    .i_set_word  (col_instr[31:0]),
    .i_set_pc    (dec_pc),
    .i_clr       (w_acc),
    .i_clr_wfid  (ib_wfid),
    .i_flush     (flush_valid),
    .i_flush_wfid(flush_wfid)
  );
  always_ff @(posedge clk)
    if (rst) begin
      r_out_valid <= 1'b0;
      col_instr   <= '0;
      col_done    <= 1'b0;
      dec_wfid    <= '0;
      dec_pc      <= '0;
      collate_err <= 1'b0;
    end else begin
      r_out_valid <= w_load || (r_out_valid && !w_free);
      collate_err <= w_err;
      if (w_load) begin
        col_instr <= w_hit ? {ib_instr, w_lo_word} : {32'h0, ib_instr};
        col_done  <= w_hit;
        dec_wfid  <= ib_wfid;
        dec_pc    <= w_hit ? w_lo_pc : ib_pc;
      end
    end
endmodule
